// File: rtl/ex_md_if.sv
// Port bundle between decode/hazard logic (master)
// and the execute stage with multiply/divide (slave).
interface ex_md_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int OP_W   = 5
);
  logic              in_valid;
  logic [OP_W-1:0]   in_op;
  logic [DATA_W-1:0] in_rs_data;
  logic [DATA_W-1:0] in_rt_data;
  logic [DATA_W-1:0] in_imm;
  logic [4:0]        in_shamt;
  logic              in_use_imm;
  logic              in_use_shamt;
  logic [REG_AW-1:0] in_rs;
  logic [REG_AW-1:0] in_rt;
  logic [REG_AW-1:0] in_rd;
  logic              in_dst_rd;
  logic              in_wr;
  logic              flush;
  logic [DATA_W-1:0] fwd_mem_data;
  logic [DATA_W-1:0] fwd_wb_data;
  logic [1:0]        fwd_sel_a;
  logic [1:0]        fwd_sel_b;
  logic              ex_stall;
  logic              out_valid;
  logic [DATA_W-1:0] out_result;
  logic [DATA_W-1:0] out_store_data;
  logic [REG_AW-1:0] out_dst;
  logic [REG_AW-1:0] out_rs;
  logic [REG_AW-1:0] out_rt;

  modport master (
    output in_valid, in_op, in_rs_data, in_rt_data,
    output in_imm, in_shamt, in_use_imm, in_use_shamt,
    output in_rs, in_rt, in_rd, in_dst_rd, in_wr,
    output flush, fwd_mem_data, fwd_wb_data,
    output fwd_sel_a, fwd_sel_b,
    input  ex_stall, out_valid, out_result,
    input  out_store_data, out_dst, out_rs, out_rt
  );

  modport slave (
    input  in_valid, in_op, in_rs_data, in_rt_data,
    input  in_imm, in_shamt, in_use_imm, in_use_shamt,
    input  in_rs, in_rt, in_rd, in_dst_rd, in_wr,
    input  flush, fwd_mem_data, fwd_wb_data,
    input  fwd_sel_a, fwd_sel_b,
    output ex_stall, out_valid, out_result,
    output out_store_data, out_dst, out_rs, out_rt
  );
endinterface

// File: rtl/ex_stage_md.sv
// Execute stage: ID/EX register, forwarding, ALU and a
// non-blocking radix-2 multiply/divide unit with HI/LO.
module ex_stage_md #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int OP_W   = 5
) (
  input logic   clk,
  input logic   reset,
  ex_md_if.slave bus
);
  localparam int SH_W = $clog2(DATA_W);

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [4:0]        shamt;
    logic              use_imm;
    logic              use_shamt;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic              dst_rd;
    logic              wr;
  } id_ex_t;

  id_ex_t q;
  logic   stall;
  logic   busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (bus.flush) begin
      q.valid <= 1'b0;
    end else if (!stall) begin
      q <= '{valid: bus.in_valid, op: bus.in_op,
             rs_data: bus.in_rs_data,
             rt_data: bus.in_rt_data,
             imm: bus.in_imm, shamt: bus.in_shamt,
             use_imm: bus.in_use_imm,
             use_shamt: bus.in_use_shamt,
             rs: bus.in_rs, rt: bus.in_rt,
             rd: bus.in_rd, dst_rd: bus.in_dst_rd,
             wr: bus.in_wr};
    end
  end

  logic [OP_W-1:0] op;
  logic is_md;
  logic is_grp;
  logic is_bad;
  logic is_sgn;
  logic is_div;

  assign op     = q.op;
  assign is_md  = op >= OP_W'(12) && op <= OP_W'(15);
  assign is_grp = op >= OP_W'(12) && op <= OP_W'(17);
  assign is_bad = op >= OP_W'(18);
  assign is_sgn = op == OP_W'(12) || op == OP_W'(14);
  assign is_div = op == OP_W'(14) || op == OP_W'(15);

  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;

  always_comb begin
    unique case (bus.fwd_sel_a)
      2'b10:   fwd_a = bus.fwd_mem_data;
      2'b01:   fwd_a = bus.fwd_wb_data;
      default: fwd_a = q.rs_data;
    endcase
    unique case (bus.fwd_sel_b)
      2'b10:   fwd_b = bus.fwd_mem_data;
      2'b01:   fwd_b = bus.fwd_wb_data;
      default: fwd_b = q.rt_data;
    endcase
  end

  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [SH_W-1:0]   sh;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic [DATA_W-1:0] res;

  assign a  = q.use_shamt ? DATA_W'(q.shamt) : fwd_a;
  assign b  = q.use_imm ? q.imm : fwd_b;
  assign sh = SH_W'(b[4:0]);

  always_comb begin
    res = a + b;
    unique case (1'b1)
      op == OP_W'(1):  res = a - b;
      op == OP_W'(2):  res = a & b;
      op == OP_W'(3):  res = a | b;
      op == OP_W'(4):  res = a ^ b;
      op == OP_W'(5):  res = ~(a | b);
      op == OP_W'(6):
        res = DATA_W'($signed(a) < $signed(b));
      op == OP_W'(7):  res = DATA_W'(a < b);
      op == OP_W'(8):  res = a << sh;
      op == OP_W'(9):  res = a >> sh;
      op == OP_W'(10):
        res = $unsigned($signed(a) >>> sh);
      op == OP_W'(11): res = b << (DATA_W / 2);
      op == OP_W'(16): res = hi;
      op == OP_W'(17): res = lo;
      default: ;
    endcase
  end

  logic issue;

  assign stall = q.valid & is_grp & busy;
  assign issue = q.valid & is_md & ~stall;

  assign bus.ex_stall       = stall;
  assign bus.out_valid      = q.valid & ~stall;
  assign bus.out_result     = q.valid ? res : '0;
  assign bus.out_store_data = q.valid ? fwd_b : '0;
  assign bus.out_rs         = q.rs;
  assign bus.out_rt         = q.rt;
  assign bus.out_dst =
    (q.valid & q.wr & ~is_md & ~is_bad) ?
    (q.dst_rd ? q.rd : q.rt) : '0;

  // acc/mq hold {product-high, multiplier} or {remainder, quotient}
  logic [SH_W-1:0]   cnt;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] mq;
  logic [DATA_W-1:0] mb;
  logic [DATA_W-1:0] dvd;
  logic              dmode;
  logic              neg_q;
  logic              neg_r;
  logic              dz;

  logic              sa;
  logic              sb;
  logic [DATA_W-1:0] mag_a;
  logic [DATA_W-1:0] mag_b;

  assign sa    = is_sgn & fwd_a[DATA_W-1];
  assign sb    = is_sgn & fwd_b[DATA_W-1];
  assign mag_a = sa ? -fwd_a : fwd_a;
  assign mag_b = sb ? -fwd_b : fwd_b;

  logic [DATA_W:0]     sum;
  logic [DATA_W:0]     shl;
  logic [DATA_W-1:0]   diff;
  logic                ge;
  logic [DATA_W-1:0]   acc_n;
  logic [DATA_W-1:0]   mq_n;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   hi_n;
  logic [DATA_W-1:0]   lo_n;
  logic                last;

  assign last = cnt == SH_W'(DATA_W - 1);

  always_comb begin
    sum  = {1'b0, acc} + (mq[0] ? {1'b0, mb} : '0);
    shl  = {acc, mq[DATA_W-1]};
    ge   = shl >= {1'b0, mb};
    diff = shl[DATA_W-1:0] - mb;
    if (dmode) begin
      acc_n = ge ? diff : shl[DATA_W-1:0];
      mq_n  = {mq[DATA_W-2:0], ge};
    end else begin
      acc_n = sum[DATA_W:1];
      mq_n  = {sum[0], mq[DATA_W-1:1]};
    end
    prod = {acc_n, mq_n};
    if (neg_q) prod = -prod;
    {hi_n, lo_n} = prod;
    if (dmode) begin
      lo_n = neg_q ? -mq_n : mq_n;
      hi_n = neg_r ? -acc_n : acc_n;
      if (dz) begin
        lo_n = '1;
        hi_n = dvd;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy  <= 1'b0;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      acc   <= '0;
      mq    <= '0;
      mb    <= '0;
      dvd   <= '0;
      dmode <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz    <= 1'b0;
    end else if (busy) begin
      acc <= acc_n;
      mq  <= mq_n;
      cnt <= cnt + SH_W'(1);
      if (last) begin
        busy <= 1'b0;
        cnt  <= '0;
        hi   <= hi_n;
        lo   <= lo_n;
      end
    end else if (issue) begin
      busy  <= 1'b1;
      cnt   <= '0;
      acc   <= '0;
      mq    <= mag_a;
      mb    <= mag_b;
      dvd   <= fwd_a;
      dmode <= is_div;
      neg_q <= sa ^ sb;
      neg_r <= sa;
      dz    <= is_div & (fwd_b == '0);
    end
  end
endmodule

// File: tb/tb_ex_stage_md.sv
// Directed and randomized bench for ex_stage_md with
// an arithmetic reference model for ALU and HI/LO.
module tb_ex_stage_md;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ex_md_if #(.DATA_W(32), .REG_AW(5), .OP_W(5)) bus ();

  ex_stage_md #(.DATA_W(32), .REG_AW(5), .OP_W(5)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    bus.fwd_sel_a = 2'b00;
    bus.fwd_sel_b = 2'b00;
  endtask

  task automatic load(input logic [4:0] op,
                      input logic [31:0] a,
                      input logic [31:0] b);
    bus.in_valid = 1'b1;
    bus.in_op = op;
    bus.in_rs_data = a;
    bus.in_rt_data = b;
    bus.in_imm = $urandom;
    bus.in_shamt = 5'd0;
    bus.in_use_imm = 1'b0;
    bus.in_use_shamt = 1'b0;
    bus.in_rs = 5'd1;
    bus.in_rt = 5'd2;
    bus.in_rd = 5'd3;
    bus.in_dst_rd = 1'b1;
    bus.in_wr = 1'b1;
    bus.flush = 1'b0;
    bus.fwd_sel_a = 2'b00;
    bus.fwd_sel_b = 2'b00;
  endtask

  function automatic logic [31:0] alu_ref(
      input logic [4:0] op,
      input logic [31:0] a,
      input logic [31:0] b);
    int s;
    s = int'(b[4:0]);
    case (op)
      5'd1:  return a - b;
      5'd2:  return a & b;
      5'd3:  return a | b;
      5'd4:  return a ^ b;
      5'd5:  return ~(a | b);
      5'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd7:  return (a < b) ? 32'd1 : 32'd0;
      5'd8:  return a << s;
      5'd9:  return a >> s;
      5'd10: return 32'($signed(a) >>> s);
      5'd11: return {b[15:0], 16'h0000};
      default: return a + b;
    endcase
  endfunction

  function automatic void md_ref(input logic [4:0] op,
                                 input logic [31:0] a,
                                 input logic [31:0] b,
                                 output logic [31:0] hi,
                                 output logic [31:0] lo);
    longint sp;
    logic [63:0] up;
    hi = 32'h0;
    lo = 32'h0;
    case (op)
      5'd12: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        {hi, lo} = sp;
      end
      5'd13: begin
        up = {32'h0, a} * {32'h0, b};
        {hi, lo} = up;
      end
      5'd14: begin
        if (b == 32'h0) begin
          lo = 32'hFFFF_FFFF;
          hi = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          lo = a;
          hi = 32'h0;
        end else begin
          lo = $signed(a) / $signed(b);
          hi = $signed(a) % $signed(b);
        end
      end
      default: begin
        if (b == 32'h0) begin
          lo = 32'hFFFF_FFFF;
          hi = a;
        end else begin
          lo = a / b;
          hi = a % b;
        end
      end
    endcase
  endfunction

  // issue one MD op, then MFHI right behind it and MFLO after
  task automatic run_md(input string tag,
                        input logic [4:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b);
    logic [31:0] eh;
    logic [31:0] el;
    int n;
    md_ref(op, a, b, eh, el);
    load(op, a, b);
    tick();
    chk({tag, "_iss_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_iss_dst"}, 32'(bus.out_dst), 32'd0);
    load(5'd16, 32'h0, 32'h0);
    tick();
    n = 0;
    while (bus.ex_stall && n < 100) begin
      chk({tag, "_stall_valid"}, 32'(bus.out_valid), 32'd0);
      tick();
      n++;
    end
    chk({tag, "_stall_cycles"}, n, 32'd32);
    chk({tag, "_hi"}, bus.out_result, eh);
    load(5'd17, 32'h0, 32'h0);
    tick();
    chk({tag, "_lo_stall"}, 32'(bus.ex_stall), 32'd0);
    chk({tag, "_lo"}, bus.out_result, el);
  endtask

  initial begin
    logic [31:0] eh;
    logic [31:0] el;
    int n;

    load(5'd0, 32'h1234, 32'h5678);
    bus.fwd_mem_data = 32'hDEAD_BEEF;
    bus.fwd_wb_data = 32'hCAFE_F00D;
    bus.fwd_sel_a = 2'b10;
    bus.fwd_sel_b = 2'b01;
    tick();
    tick();
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result", bus.out_result, 32'd0);
    chk("rst_store", bus.out_store_data, 32'd0);
    chk("rst_dst", 32'(bus.out_dst), 32'd0);
    chk("rst_rs_rt", 32'({bus.out_rs, bus.out_rt}), 32'd0);
    chk("rst_stall", 32'(bus.ex_stall), 32'd0);
    #3 reset = 1'b1;
    idle();
    tick();

    load(5'd0, 32'h1, 32'd7);
    bus.fwd_mem_data = 32'd5;
    bus.fwd_sel_a = 2'b10;
    tick();
    chk("add_result", bus.out_result, 32'd12);
    chk("add_dst", 32'(bus.out_dst), 32'd3);
    chk("add_valid", 32'(bus.out_valid), 32'd1);
    chk("add_rs", 32'(bus.out_rs), 32'd1);
    chk("add_rt", 32'(bus.out_rt), 32'd2);

    for (int i = 0; i < 40; i++) begin
      logic [4:0] op;
      logic [31:0] fa;
      logic [31:0] fb;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0] ed;
      op = 5'($urandom_range(0, 25));
      if (op >= 5'd12) op = op + 5'd6;
      load(op, $urandom, $urandom);
      bus.in_shamt = 5'($urandom);
      bus.in_use_imm = 1'($urandom);
      bus.in_use_shamt = 1'($urandom);
      bus.in_rs = 5'($urandom);
      bus.in_rt = 5'($urandom);
      bus.in_rd = 5'($urandom);
      bus.in_dst_rd = 1'($urandom);
      bus.in_wr = 1'($urandom);
      bus.fwd_mem_data = $urandom;
      bus.fwd_wb_data = $urandom;
      bus.fwd_sel_a = 2'($urandom);
      bus.fwd_sel_b = 2'($urandom);
      tick();
      fa = bus.fwd_sel_a == 2'b10 ? bus.fwd_mem_data :
           bus.fwd_sel_a == 2'b01 ? bus.fwd_wb_data :
           bus.in_rs_data;
      fb = bus.fwd_sel_b == 2'b10 ? bus.fwd_mem_data :
           bus.fwd_sel_b == 2'b01 ? bus.fwd_wb_data :
           bus.in_rt_data;
      a = bus.in_use_shamt ? {27'h0, bus.in_shamt} : fa;
      b = bus.in_use_imm ? bus.in_imm : fb;
      ed = (bus.in_wr && op < 5'd18) ?
           (bus.in_dst_rd ? bus.in_rd : bus.in_rt) : 5'd0;
      chk("alu_result", bus.out_result, alu_ref(op, a, b));
      chk("alu_dst", 32'(bus.out_dst), 32'(ed));
      chk("alu_store", bus.out_store_data, fb);
      chk("alu_valid", 32'(bus.out_valid), 32'd1);
    end

    run_md("mult_tp", 5'd12, 32'd7, 32'hFFFF_FFFD);
    for (int i = 0; i < 6; i++) begin
      logic [31:0] b;
      b = (i % 3 == 0) ? 32'h0 : ($urandom >> $urandom_range(0, 31));
      run_md("md_rand", 5'(12 + i % 4), $urandom, b);
    end

    load(5'd14, 32'hFFFF_FFF9, 32'd2);
    tick();
    chk("div_iss_valid", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < 31; i++) begin
      logic [4:0] op;
      op = (i % 2 == 0) ? 5'd0 : 5'd3;
      load(op, $urandom, $urandom);
      tick();
      chk("fill_stall", 32'(bus.ex_stall), 32'd0);
      chk("fill_result", bus.out_result,
          alu_ref(op, bus.in_rs_data, bus.in_rt_data));
    end
    load(5'd17, 32'h0, 32'h0);
    tick();
    n = 0;
    while (bus.ex_stall && n < 100) begin
      tick();
      n++;
    end
    chk("fill_mflo_stall", n, 32'd1);
    chk("fill_lo", bus.out_result, 32'hFFFF_FFFD);
    load(5'd16, 32'h0, 32'h0);
    tick();
    chk("fill_hi_stall", 32'(bus.ex_stall), 32'd0);
    chk("fill_hi", bus.out_result, 32'hFFFF_FFFF);

    run_md("divu_z", 5'd15, 32'd9, 32'd0);
    run_md("div_ovf", 5'd14, 32'h8000_0000, 32'hFFFF_FFFF);

    md_ref(5'd15, 32'd1000, 32'd7, eh, el);
    load(5'd15, 32'd1000, 32'd7);
    tick();
    load(5'd17, 32'h0, 32'h0);
    tick();
    chk("fl_stalled", 32'(bus.ex_stall), 32'd1);
    idle();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("fl_valid", 32'(bus.out_valid), 32'd0);
    chk("fl_stall", 32'(bus.ex_stall), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("fl_bubble", 32'(bus.out_valid), 32'd0);
    end
    load(5'd17, 32'h0, 32'h0);
    tick();
    n = 0;
    while (bus.ex_stall && n < 100) begin
      tick();
      n++;
    end
    chk("fl_wait", 32'(n < 100), 32'd1);
    chk("fl_lo", bus.out_result, el);
    load(5'd16, 32'h0, 32'h0);
    tick();
    chk("fl_hi", bus.out_result, eh);

    load(5'd14, $urandom | 32'h1000, 32'd3);
    tick();
    idle();
    for (int i = 0; i < 9; i++) tick();
    load(5'd0, 32'd5, 32'd6);
    tick();
    chk("mid_add", bus.out_result, 32'd11);
    #2 reset = 1'b0;
    #1;
    chk("mid_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_result", bus.out_result, 32'd0);
    chk("mid_dst", 32'(bus.out_dst), 32'd0);
    chk("mid_store", bus.out_store_data, 32'd0);
    chk("mid_rs_rt", 32'({bus.out_rs, bus.out_rt}), 32'd0);
    tick();
    #3 reset = 1'b1;
    load(5'd16, 32'h0, 32'h0);
    tick();
    chk("post_hi_stall", 32'(bus.ex_stall), 32'd0);
    chk("post_hi_valid", 32'(bus.out_valid), 32'd1);
    chk("post_hi", bus.out_result, 32'd0);
    load(5'd17, 32'h0, 32'h0);
    tick();
    chk("post_lo", bus.out_result, 32'd0);
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
